// File: rtl/key_direction.sv
// PS/2 set-2 scan-code parser: W/A/S/D and arrow make/break into a held mask and a per-frame direction code.
// Latency: held updates at the byte's edge; USER_INPUT updates at the next frame_tick. No backpressure.
module key_direction #(
  parameter int unsigned PREFIX_TIMEOUT = 1_000_000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  input  logic       frame_tick,
  output logic [2:0] USER_INPUT,
  output logic [3:0] held,
  output logic       seq_err
);

  localparam int CW = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  // Direction index doubles as the bit position in the held mask.
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  state_t          state_q;
  logic [3:0]      held_q;
  logic [1:0]      last_q;
  logic            last_v_q;
  logic [2:0]      ui_q;
  logic            seq_err_q;
  logic [CW-1:0]   cnt_q;

  logic            is_ext;
  logic            is_brk;
  logic            hit;
  logic [1:0]      dir;
  logic [1:0]      cand_dir;
  logic            cand_v;
  logic [2:0]      ui_d;

  assign is_ext = (state_q == S_EXT) || (state_q == S_EXT_BRK);
  assign is_brk = (state_q == S_BRK) || (state_q == S_EXT_BRK);

  always_comb begin
    hit = 1'b0;
    dir = DIR_UP;
    if (is_ext) begin
      case (scan_code)
        8'h75: begin hit = 1'b1; dir = DIR_UP;    end
        8'h6B: begin hit = 1'b1; dir = DIR_LEFT;  end
        8'h72: begin hit = 1'b1; dir = DIR_DOWN;  end
        8'h74: begin hit = 1'b1; dir = DIR_RIGHT; end
        default: ;
      endcase
    end else begin
      case (scan_code)
        8'h1D: begin hit = 1'b1; dir = DIR_UP;    end
        8'h1C: begin hit = 1'b1; dir = DIR_LEFT;  end
        8'h1B: begin hit = 1'b1; dir = DIR_DOWN;  end
        8'h23: begin hit = 1'b1; dir = DIR_RIGHT; end
        default: ;
      endcase
    end
  end

  // Most recent press wins; otherwise fall back to the fixed priority over held keys.
  always_comb begin
    cand_v   = 1'b1;
    cand_dir = last_q;
    if (!last_v_q) begin
      if (held_q[0])      cand_dir = DIR_UP;
      else if (held_q[1]) cand_dir = DIR_LEFT;
      else if (held_q[2]) cand_dir = DIR_DOWN;
      else if (held_q[3]) cand_dir = DIR_RIGHT;
      else                cand_v   = 1'b0;
    end
    ui_d = 3'b000;
    if (cand_v) begin
      case (cand_dir)
        DIR_UP:    ui_d = 3'b001;
        DIR_LEFT:  ui_d = 3'b010;
        DIR_DOWN:  ui_d = 3'b100;
        default:   ui_d = 3'b101;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      held_q    <= 4'b0000;
      last_q    <= DIR_UP;
      last_v_q  <= 1'b0;
      ui_q      <= 3'b000;
      seq_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      seq_err_q <= 1'b0;
      if (frame_tick) ui_q <= ui_d;

      if (scan_valid) begin
        cnt_q <= '0;
        if (scan_code == 8'hE0) begin
          state_q <= S_EXT;
        end else if (scan_code == 8'hF0) begin
          case (state_q)
            S_IDLE:  state_q <= S_BRK;
            S_EXT:   state_q <= S_EXT_BRK;
            default: state_q <= state_q;
          endcase
        end else begin
          state_q <= S_IDLE;
          if (hit) begin
            if (!is_brk) begin
              if (!held_q[dir]) begin
                held_q[dir] <= 1'b1;
                last_q      <= dir;
                last_v_q    <= 1'b1;
              end
            end else if (held_q[dir]) begin
              held_q[dir] <= 1'b0;
              if (last_q == dir) last_v_q <= 1'b0;
            end
          end
        end
      end else if (state_q != S_IDLE) begin
        if (cnt_q == CW'(PREFIX_TIMEOUT - 1)) begin
          state_q   <= S_IDLE;
          cnt_q     <= '0;
          seq_err_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  assign USER_INPUT = ui_q;
  assign held       = held_q;
  assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_key_direction.sv
// Directed bench for key_direction: held mask checked after each byte, USER_INPUT checked at each frame tick.
module tb_key_direction;

  logic       Clk;
  logic       Reset_n;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_tick;
  logic [2:0] USER_INPUT;
  logic [3:0] held;
  logic       seq_err;

  int n_vec = 0;
  int n_err = 0;
  logic [2:0] exp_q[$];

  key_direction #(.PREFIX_TIMEOUT(8)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .frame_tick (frame_tick),
    .USER_INPUT (USER_INPUT),
    .held       (held),
    .seq_err    (seq_err)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    scan_code  = b;
    scan_valid = 1'b1;
    @(posedge Clk);
    #1;
    scan_valid = 1'b0;
    scan_code  = 8'h00;
  endtask

  task automatic push_ui(input logic [2:0] e);
    exp_q.push_back(e);
  endtask

  task automatic pop_check_ui(input string tag);
    logic [2:0] e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: observed %0h with no expected value queued", tag, USER_INPUT);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {5'd0, USER_INPUT}, {5'd0, e});
    end
  endtask

  task automatic tick(input string tag);
    frame_tick = 1'b1;
    @(posedge Clk);
    #1;
    frame_tick = 1'b0;
    pop_check_ui(tag);
  endtask

  initial begin
    int pulses;
    int first_at;

    Reset_n    = 1'b0;
    scan_code  = 8'h00;
    scan_valid = 1'b0;
    frame_tick = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_ui",   {5'd0, USER_INPUT}, 8'h00);
    chk("rst_held", {4'd0, held},       8'h00);
    chk("rst_err",  {7'd0, seq_err},    8'h00);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    // Plain W make then break.
    send_byte(8'h1D);
    chk("w_make_held", {4'd0, held}, 8'h01);
    push_ui(3'b001); tick("w_make_ui");
    send_byte(8'hF0); send_byte(8'h1D);
    chk("w_brk_held", {4'd0, held}, 8'h00);
    push_ui(3'b000); tick("w_brk_ui");

    // Arrow left then D; releasing D falls back to left.
    send_byte(8'hE0); send_byte(8'h6B);
    chk("left_held", {4'd0, held}, 8'h02);
    send_byte(8'h23);
    chk("ld_held", {4'd0, held}, 8'h0A);
    push_ui(3'b101); tick("ld_ui");
    send_byte(8'hF0); send_byte(8'h23);
    chk("d_brk_held", {4'd0, held}, 8'h02);
    push_ui(3'b010); tick("fallback_left_ui");
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
    chk("left_brk_held", {4'd0, held}, 8'h00);
    push_ui(3'b000); tick("clear1_ui");

    // S with typematic repeats, then A on top.
    send_byte(8'h1B);
    chk("s_held", {4'd0, held}, 8'h04);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h1B);
      chk("s_repeat_held", {4'd0, held}, 8'h04);
    end
    send_byte(8'h1C);
    chk("sa_held", {4'd0, held}, 8'h06);
    push_ui(3'b010); tick("sa_ui");
    send_byte(8'hF0); send_byte(8'h1C);
    chk("a_brk_held", {4'd0, held}, 8'h04);
    push_ui(3'b100); tick("fallback_down_ui");
    send_byte(8'hF0); send_byte(8'h1B);
    chk("s_brk_held", {4'd0, held}, 8'h00);
    push_ui(3'b000); tick("clear2_ui");

    // Break of an unheld key, and an unmapped extended byte aborting the prefix.
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
    chk("brk_unheld_held", {4'd0, held}, 8'h00);
    send_byte(8'hE0); send_byte(8'h12); send_byte(8'h75);
    chk("unmapped_held", {4'd0, held}, 8'h00);
    push_ui(3'b000); tick("unmapped_ui");

    // Byte coinciding with frame_tick shows up only at the following tick.
    scan_code  = 8'h1D;
    scan_valid = 1'b1;
    frame_tick = 1'b1;
    push_ui(3'b000);
    @(posedge Clk);
    #1;
    scan_valid = 1'b0;
    frame_tick = 1'b0;
    pop_check_ui("coincide_ui");
    chk("coincide_held", {4'd0, held}, 8'h01);
    push_ui(3'b001); tick("coincide_next_ui");
    send_byte(8'hF0); send_byte(8'h1D);
    push_ui(3'b000); tick("clear3_ui");

    // Prefix timeout: lone E0, then watch for exactly one seq_err pulse.
    send_byte(8'hE0);
    pulses   = 0;
    first_at = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge Clk);
      #1;
      if (seq_err) begin
        pulses++;
        if (first_at == 0) first_at = k;
      end
    end
    chk("timeout_pulses", pulses[7:0], 8'd1);
    chk("timeout_cycle",  first_at[7:0], 8'd8);
    send_byte(8'h75);
    chk("after_timeout_held", {4'd0, held}, 8'h00);
    send_byte(8'hE0); send_byte(8'h75);
    chk("arrow_up_held", {4'd0, held}, 8'h01);
    push_ui(3'b001); tick("arrow_up_ui");

    // Asynchronous reset mid-sequence clears outputs without a clock edge.
    send_byte(8'hE0);
    Reset_n = 1'b0;
    #1;
    chk("async_rst_ui",   {5'd0, USER_INPUT}, 8'h00);
    chk("async_rst_held", {4'd0, held},       8'h00);
    chk("async_rst_err",  {7'd0, seq_err},    8'h00);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    send_byte(8'h75);
    chk("post_rst_plain_held", {4'd0, held}, 8'h00);
    send_byte(8'h1D);
    chk("post_rst_w_held", {4'd0, held}, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/key_direction.md
# key_direction

Converts the PS/2 set-2 scan-code byte stream into the 3-bit `USER_INPUT` direction code consumed by the `motion` position-update stage. It tracks make and break sequences for W/A/S/D and the four arrow keys, and keeps a held-key mask with most-recent-press priority. It presents one stable direction per frame, sampled on `frame_tick`, so the `motion` stage moves at most one step per frame.

## Interface
- `PREFIX_TIMEOUT`, default 1_000_000: number of cycles a partial prefix sequence may wait for its next byte before the decoder abandons it.
- `Clk`  in  1  system clock; all state changes on its rising edge.
- `Reset_n`  in  1  one clock; reset is asynchronous and active-low.
- `scan_code`  in  8  received scan-code byte; sampled only when `scan_valid` is 1.
- `scan_valid`  in  1  single-cycle strobe, one per received byte.
- `frame_tick`  in  1  single-cycle pulse, once per video frame.
- `USER_INPUT`  out  3  registered direction: 3'b001 up, 3'b010 left, 3'b100 down, 3'b101 right, 3'b000 none.
- `held`  out  4  registered held mask {right, down, left, up}.
- `seq_err`  out  1  one-cycle pulse on a prefix timeout.

## Operation
- Key map:
  - Up: 8'h1D (W) or E0 75.
  - Left: 8'h1C (A) or E0 6B.
  - Down: 8'h1B (S) or E0 72.
  - Right: 8'h23 (D) or E0 74.
  - The plain letter and the arrow for a direction drive the same `held` bit.
- Parser FSM states: IDLE, EXT (seen E0), BRK (seen F0), EXT_BRK (seen E0 F0). Reset state is IDLE.
- Parser transitions, evaluated only on `scan_valid`:
  - E0 from any state goes to EXT.
  - F0 goes IDLE→BRK and EXT→EXT_BRK. F0 in BRK or EXT_BRK stays in that state.
  - Any other byte returns to IDLE. If the byte is a mapped code for the current state (plain in IDLE/BRK, extended in EXT/EXT_BRK), the FSM performs a make (IDLE/EXT) or a break (BRK/EXT_BRK).
  - Unmapped bytes are discarded with no other effect.
- Make action:
  - If the `held` bit is already set (typematic repeat), nothing changes.
  - Otherwise, set the bit, set `last` to that direction, and set `last_v` to 1.
- Break action:
  - Clear the `held` bit. If it was already clear, nothing else happens.
  - If the released direction equals `last`, clear `last_v`.
- Candidate direction:
  - If `last_v` is 1, the candidate is `last`.
  - Else the highest-priority set bit of `held`, in order up > left > down > right.
  - Else none.
- `USER_INPUT` loads the encoded candidate only in a cycle with `frame_tick`=1. Otherwise it holds its value.
- Prefix timeout:
  - A counter runs while the FSM is outside IDLE and resets to 0 whenever a byte arrives.
  - When it reaches PREFIX_TIMEOUT-1, the FSM returns to IDLE and `seq_err` pulses. `held` and `last` are unchanged.

## Timing
- Reset values (asynchronous assertion; release synchronised by the system): FSM IDLE, `held`=4'b0000, `last_v`=0, `last`=up, `USER_INPUT`=3'b000, `seq_err`=0, timeout counter 0.
- A byte with `scan_valid` at edge N updates the FSM, `held`, and `last` at edge N. `held` is visible after edge N.
- `USER_INPUT` changes only at an edge where `frame_tick`=1, and it reflects the state before that same edge. If `scan_valid` and `frame_tick` coincide, the byte's effect first appears at the following frame tick.
- Latency from the final byte of a sequence to a visible `USER_INPUT` change is 1 cycle up to one frame period.
- `seq_err` is high for exactly the one cycle following the timeout edge.
- The block has no backpressure. It accepts `scan_valid` every cycle, including back-to-back bytes.

## Test plan
- Reset, then send 1D and pulse `frame_tick` → `held`=0001, `USER_INPUT`=001. Then send F0 1D and pulse `frame_tick` → `held`=0000, `USER_INPUT`=000.
- Send E0 6B (left), then 23 (D), then tick → `USER_INPUT`=101. Send F0 23, then tick → `last_v`=0, fallback gives 010.
- Hold 1B (S) and send 1B three more times as typematic repeats, then send 1C (A) and tick → 010. Send F0 1C, then tick → 100. `held` stays 0100 throughout the repeats of 1B.
- Send E0 F0 74 with no right key held → `held` unchanged. Send E0 12 (unmapped) then 75 → FSM returns to IDLE after 12, and 75 alone is ignored, so `held`=0000.
- Send 1D with `scan_valid` in the same cycle as `frame_tick` → `USER_INPUT` stays 000 at that tick and becomes 001 at the next tick.
- With PREFIX_TIMEOUT=8, send E0 and then nothing → `seq_err` pulses once, 8 cycles after E0, and FSM is IDLE. A following 75 is treated as plain and ignored. Asserting `Reset_n`=0 mid-sequence clears all outputs immediately.
